// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive channel.
// Holds the receiver FSM state type, output buffer depth and a word-length mask helper.
// No logic of its own; imported by the channel top and its shift registers.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUNNING
  } rx_state_e;

  localparam int unsigned BUF_DEPTH = 2;

  // Ones in bits [wlen:0], zeros above.
  function automatic logic [31:0] wlen_mask(input logic [4:0] wlen);
    return 32'hFFFF_FFFF >> (5'd31 - wlen);
  endfunction

endpackage

// File: rtl/i2s_rx_shreg.sv
// 32-bit serial-to-parallel shift register for one I2S data line.
// Latency: a bit inserted on a rising edge is visible right after that edge.
// No backpressure; clear applies to the same edge as the insert so a new word starts from zero.
module i2s_rx_shreg
  import i2s_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic        bit_i,
  input  logic        lsb_first_i,
  input  logic [4:0]  wlen_i,
  output logic [31:0] data_o
);

  logic [31:0] data_q;
  logic [31:0] data_d;
  logic [31:0] base;

  // Next word value: optionally clear, then insert the new bit in the configured direction.
  always_comb begin
    base   = clr_i ? 32'h0 : data_q;
    data_d = data_q;
    if (shift_i) begin
      if (lsb_first_i) begin
        data_d         = base >> 1;
        data_d[wlen_i] = bit_i;
      end else begin
        data_d = {base[30:0], bit_i};
      end
      data_d = data_d & wlen_mask(wlen_i);
    end
  end

  // Word register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/i2s_rx_channel.sv
// I2S receiver: one or two serial channels assembled into right-aligned 32-bit words.
// Latency: word pushed one sck cycle after its last bit; ch1 follows ch0 a cycle later.
// Backpressure: 2-entry buffer; if a word boundary does not fit, the whole boundary is dropped and
// fifo_err_o pulses. Optional sign extension of pushed words under I2S_RX_SIGN_EXT_EN.
module i2s_rx_channel
  import i2s_pkg::*;
(
  input  logic        sck_i,
  input  logic        rst_i,
  input  logic        i2s_ch0_i,
  input  logic        i2s_ch1_i,
  input  logic        i2s_ws_i,
  output logic [31:0] fifo_data_o,
  output logic        fifo_data_valid_o,
  input  logic        fifo_data_ready_i,
  output logic        fifo_err_o,
  input  logic        cfg_en_i,
  input  logic        cfg_2ch_i,
  input  logic [4:0]  cfg_wlen_i,
  input  logic        cfg_lsb_first_i
);

  rx_state_e   state_q;
  logic [4:0]  cnt_q;
  logic        done_q;
  logic        r_ws_q;
  logic        ws_edge;
  logic        soft_rst;
  logic        shift_en;
  logic        word_clr;
  logic [31:0] sh0, sh1;
  logic [31:0] w0, w1;

  logic [31:0] buf_q [2];
  logic [31:0] buf_d [2];
  logic [1:0]  fill_q, fill_d, fill_pop, nwr;
  logic        err_q, err_d, pop;

  assign ws_edge  = i2s_ws_i ^ r_ws_q;
  // Disabling the channel behaves like reset for everything except the WS history.
  assign soft_rst = rst_i | ~cfg_en_i;
  assign shift_en = cfg_en_i & (((state_q == ST_SYNC) & ws_edge) | (state_q == ST_RUNNING));
  assign word_clr = (state_q == ST_SYNC) | (cnt_q == 5'd0);

  i2s_rx_shreg u_shreg_ch0 (
    .clk_i       (sck_i),
    .rst_i       (soft_rst),
    .clr_i       (word_clr),
    .shift_i     (shift_en),
    .bit_i       (i2s_ch0_i),
    .lsb_first_i (cfg_lsb_first_i),
    .wlen_i      (cfg_wlen_i),
    .data_o      (sh0)
  );

  i2s_rx_shreg u_shreg_ch1 (
    .clk_i       (sck_i),
    .rst_i       (soft_rst),
    .clr_i       (word_clr),
    .shift_i     (shift_en & cfg_2ch_i),
    .bit_i       (i2s_ch1_i),
    .lsb_first_i (cfg_lsb_first_i),
    .wlen_i      (cfg_wlen_i),
    .data_o      (sh1)
  );

`ifdef I2S_RX_SIGN_EXT_EN
  // Replicate the word's top bit into the unused upper bits.
  always_comb begin
    w0 = sh0[cfg_wlen_i] ? (sh0 | ~wlen_mask(cfg_wlen_i)) : sh0;
    w1 = sh1[cfg_wlen_i] ? (sh1 | ~wlen_mask(cfg_wlen_i)) : sh1;
  end
`else
  assign w0 = sh0;
  assign w1 = sh1;
`endif

  // Framing FSM: wait for enable, lock onto a WS edge, then count bits free-running.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      r_ws_q  <= 1'b0;
    end else begin
      r_ws_q <= i2s_ws_i;
      if (!cfg_en_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state_q)
          ST_IDLE: state_q <= ST_SYNC;
          ST_SYNC: begin
            if (ws_edge) begin
              state_q <= ST_RUNNING;
              cnt_q   <= 5'd1;
            end
          end
          ST_RUNNING: begin
            if (cnt_q == cfg_wlen_i) begin
              cnt_q  <= '0;
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Buffer update: pop first, then write the whole boundary only if it fits.
  always_comb begin
    pop      = fifo_data_valid_o & fifo_data_ready_i;
    buf_d[0] = pop ? buf_q[1] : buf_q[0];
    buf_d[1] = buf_q[1];
    fill_pop = fill_q - {1'b0, pop};
    fill_d   = fill_pop;
    err_d    = 1'b0;
    nwr      = done_q ? (cfg_2ch_i ? 2'd2 : 2'd1) : 2'd0;
    if (nwr != 2'd0) begin
      if (nwr > (2'(BUF_DEPTH) - fill_pop)) begin
        err_d = 1'b1;
      end else begin
        if (fill_pop == 2'd0) begin
          buf_d[0] = w0;
          buf_d[1] = w1;
        end else begin
          buf_d[1] = w0;
        end
        fill_d = fill_pop + nwr;
      end
    end
  end

  // Buffer and error pulse registers.
  always_ff @(posedge sck_i) begin
    if (soft_rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  assign fifo_data_valid_o = (fill_q != 2'd0);
  assign fifo_data_o       = fifo_data_valid_o ? buf_q[0] : 32'h0;
  assign fifo_err_o        = err_q;

endmodule

// File: tb/tb_i2s_rx_channel.sv
// Directed bench for i2s_rx_channel: drives serial data on the falling edge, checks on the falling edge.
module tb_i2s_rx_channel;

  logic        sck = 1'b0;
  logic        rst = 1'b1;
  logic        ch0 = 1'b0, ch1 = 1'b0, ws = 1'b0;
  logic [31:0] data;
  logic        valid, err;
  logic        ready = 1'b1;
  logic        en = 1'b0, two = 1'b0, lsb = 1'b0;
  logic [4:0]  wlen = 5'd15;

  int n_checks = 0;
  int n_err    = 0;
  int err_seen = 0;

  always #5 sck = ~sck;

  i2s_rx_channel dut (
    .sck_i             (sck),
    .rst_i             (rst),
    .i2s_ch0_i         (ch0),
    .i2s_ch1_i         (ch1),
    .i2s_ws_i          (ws),
    .fifo_data_o       (data),
    .fifo_data_valid_o (valid),
    .fifo_data_ready_i (ready),
    .fifo_err_o        (err),
    .cfg_en_i          (en),
    .cfg_2ch_i         (two),
    .cfg_wlen_i        (wlen),
    .cfg_lsb_first_i   (lsb)
  );

  always @(negedge sck) if (err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic setup(input logic [4:0] wl, input logic two_ch, input logic lsb_f, input logic rdy);
    @(negedge sck);
    en = 1'b0; wlen = wl; two = two_ch; lsb = lsb_f; ready = rdy;
    @(negedge sck);
    en = 1'b1;
    @(negedge sck);
  endtask

  // Serial word sent MSB first in time; WS toggles with the first bit.
  task automatic send_word(input logic [31:0] w0, input logic [31:0] w1, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge sck);
      if (i == 0) ws = ~ws;
      ch0 = w0[nbits-1-i];
      ch1 = w1[nbits-1-i];
    end
  endtask

  initial begin
    int base_err;
    int vcnt;
    logic [31:0] sx_exp;

    // Reset values
    repeat (3) @(negedge sck);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_err",   {31'b0, err},   32'h0);
    check("rst_data",  data,           32'h0);
    rst = 1'b0;

    // 16-bit MSB-first, one channel
    setup(5'd15, 1'b0, 1'b0, 1'b1);
    send_word(32'hA5C3, 32'h0, 16);
    @(negedge sck); check("msb_lat0",  {31'b0, valid}, 32'h0);
    @(negedge sck); check("msb_valid", {31'b0, valid}, 32'h1);
    check("msb_data", data, 32'h0000A5C3);
    @(negedge sck); check("msb_popped", {31'b0, valid}, 32'h0);

    // Same serial bits, LSB-first assembly
    setup(5'd15, 1'b0, 1'b1, 1'b1);
    send_word(32'hA5C3, 32'h0, 16);
    @(negedge sck);
    @(negedge sck); check("lsb_valid", {31'b0, valid}, 32'h1);
    check("lsb_data", data, 32'h0000C3A5);

    // Two channels, 8-bit words
    setup(5'd7, 1'b1, 1'b0, 1'b1);
    send_word(32'h12, 32'h34, 8);
    @(negedge sck); check("2ch_lat0",  {31'b0, valid}, 32'h0);
    @(negedge sck); check("2ch_v0",    {31'b0, valid}, 32'h1);
    check("2ch_ch0", data, 32'h12);
    @(negedge sck); check("2ch_v1",    {31'b0, valid}, 32'h1);
    check("2ch_ch1", data, 32'h34);
    @(negedge sck); check("2ch_empty", {31'b0, valid}, 32'h0);

    // Overflow: ready low, second pair dropped
    setup(5'd7, 1'b1, 1'b0, 1'b0);
    send_word(32'h12, 32'h34, 8);
    base_err = err_seen;
    send_word(32'h56, 32'h78, 8);
    @(negedge sck); check("ovf_err_pre",  {31'b0, err}, 32'h0);
    @(negedge sck); check("ovf_err",      {31'b0, err}, 32'h1);
    @(negedge sck); check("ovf_err_post", {31'b0, err}, 32'h0);
    check("ovf_err_cycles", 32'(err_seen - base_err), 32'd1);
    check("ovf_valid", {31'b0, valid}, 32'h1);
    check("ovf_head", data, 32'h12);
    ready = 1'b1;
    @(negedge sck); check("ovf_second", data, 32'h34);
    @(negedge sck); check("ovf_empty", {31'b0, valid}, 32'h0);

    // Sign extension of an 8-bit word with the top bit set
`ifdef I2S_RX_SIGN_EXT_EN
    sx_exp = 32'hFFFFFF80;
`else
    sx_exp = 32'h00000080;
`endif
    setup(5'd7, 1'b0, 1'b0, 1'b1);
    send_word(32'h80, 32'h0, 8);
    @(negedge sck);
    @(negedge sck); check("sx_valid", {31'b0, valid}, 32'h1);
    check("sx_data", data, sx_exp);

    // Reset at bit 5 of a word discards it; capture resumes only after a new WS edge
    setup(5'd15, 1'b0, 1'b0, 1'b1);
    send_word(32'hFFFF, 32'h0, 5);
    base_err = err_seen;
    @(negedge sck); ch0 = 1'b1; rst = 1'b1;
    @(negedge sck); rst = 1'b0;
    check("mid_rst_valid", {31'b0, valid}, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge sck);
      ch0 = ~ch0;
      if (valid === 1'b1) vcnt++;
    end
    check("mid_rst_no_push", 32'(vcnt), 32'd0);
    check("mid_rst_no_err",  32'(err_seen - base_err), 32'd0);
    send_word(32'hBEEF, 32'h0, 16);
    @(negedge sck);
    @(negedge sck); check("resync_valid", {31'b0, valid}, 32'h1);
    check("resync_data", data, 32'h0000BEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
